microwave_timer: RTL and testbench

- Time-setting and countdown stage directly downstream of the keypad encoder.
- Consumes the encoder's BCD digit `D`, its `load` level (high when no key is pressed) and its `pgt_1Hz` tick.
- Holds a 4-digit BCD mm:ss value: key presses shift digits in while idle, and the value counts down once per tick while cooking.
- Drives the display digits and a done indication for the magnetron/alarm controller.

---
 rtl/microwave_timer_if.sv | 24 ++
 rtl/microwave_timer.sv | 120 ++++++++++++
 tb/tb_microwave_timer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_if.sv
// Signal bundle between the keypad encoder/controller side and the microwave_timer stage.
interface microwave_timer_if;
  logic [3:0] D;
  logic       load;
  logic       pgt_1Hz;
  logic       en;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       zero;
  logic       done;

  modport master (
    output D, load, pgt_1Hz, en, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, zero, done
  );

  modport slave (
    input  D, load, pgt_1Hz, en, clear,
    output sec_ones, sec_tens, min_ones, min_tens, zero, done
  );
endinterface

// File: rtl/microwave_timer.sv
// mm:ss BCD entry/countdown timer fed by the keypad encoder.
// Optional macro TIMER_ENTRY_LOCK_EN: once min_tens is nonzero, further key presses are ignored.
module microwave_timer #(
  parameter int SEC_TENS_WRAP = 5,
  parameter int MIN_TENS_MAX  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  microwave_timer_if.slave  bus
);

  localparam logic [3:0] LP_WRAP = 4'(SEC_TENS_WRAP);
  localparam logic [3:0] LP_MAX  = 4'(MIN_TENS_MAX);

  logic       r_load_q;
  logic       r_tick_q;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic       r_done;

  logic       w_key_fall;
  logic       w_tick_rise;
  logic       w_zero;
  logic       w_count;
  logic       w_entry;
  logic       w_entry_ok;
  logic [3:0] w_dec_so;
  logic [3:0] w_dec_st;
  logic [3:0] w_dec_mo;
  logic [3:0] w_dec_mt;
  logic       w_dec_zero;

  assign w_key_fall  = r_load_q & ~bus.load;
  assign w_tick_rise = ~r_tick_q & bus.pgt_1Hz;
  assign w_zero      = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) &&
                       (r_min_ones == 4'd0) && (r_min_tens == 4'd0);

`ifdef TIMER_ENTRY_LOCK_EN
  assign w_entry_ok = (r_min_ones <= LP_MAX) && (r_min_tens == 4'd0);
`else
  assign w_entry_ok = (r_min_ones <= LP_MAX);
`endif

  assign w_count = bus.en & w_tick_rise & ~w_zero;
  assign w_entry = ~bus.en & w_key_fall & (bus.D <= 4'd9) & w_entry_ok;

  // BCD decrement with borrow chain; min_tens only borrows into when the value is nonzero
  always_comb begin
    w_dec_so = r_sec_ones;
    w_dec_st = r_sec_tens;
    w_dec_mo = r_min_ones;
    w_dec_mt = r_min_tens;
    if (r_sec_ones != 4'd0) begin
      w_dec_so = r_sec_ones - 4'd1;
    end else begin
      w_dec_so = 4'd9;
      if (r_sec_tens != 4'd0) begin
        w_dec_st = r_sec_tens - 4'd1;
      end else begin
        w_dec_st = LP_WRAP;
        if (r_min_ones != 4'd0) begin
          w_dec_mo = r_min_ones - 4'd1;
        end else begin
          w_dec_mo = 4'd9;
          w_dec_mt = r_min_tens - 4'd1;
        end
      end
    end
  end

  assign w_dec_zero = (w_dec_so == 4'd0) && (w_dec_st == 4'd0) &&
                      (w_dec_mo == 4'd0) && (w_dec_mt == 4'd0);

  // Edge-detect history and digit/done registers; clear beats count beats entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_q   <= 1'b1;
      r_tick_q   <= 1'b0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_load_q <= bus.load;
      r_tick_q <= bus.pgt_1Hz;
      if (bus.clear) begin
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_min_tens <= 4'd0;
        r_done     <= 1'b0;
      end else if (w_count) begin
        r_sec_ones <= w_dec_so;
        r_sec_tens <= w_dec_st;
        r_min_ones <= w_dec_mo;
        r_min_tens <= w_dec_mt;
        r_done     <= w_dec_zero;
      end else if (w_entry) begin
        r_min_tens <= r_min_ones;
        r_min_ones <= r_sec_tens;
        r_sec_tens <= r_sec_ones;
        r_sec_ones <= bus.D;
        r_done     <= 1'b0;
      end else begin
        r_done     <= 1'b0;
      end
    end
  end

  assign bus.sec_ones = r_sec_ones;
  assign bus.sec_tens = r_sec_tens;
  assign bus.min_ones = r_min_ones;
  assign bus.min_tens = r_min_tens;
  assign bus.zero     = w_zero;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: vector table, directed corner cases, random vs. digit-array model.
module tb_microwave_timer;

  localparam int SEC_TENS_WRAP = 5;
  localparam int MIN_TENS_MAX  = 9;

  logic clk;
  logic rst_n;
  microwave_timer_if bus ();

  microwave_timer #(
    .SEC_TENS_WRAP (SEC_TENS_WRAP),
    .MIN_TENS_MAX  (MIN_TENS_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: digit array index 0=sec_ones .. 3=min_tens
  int m[4];
  int wrap[4];
  bit m_lq, m_tq, m_done;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    m_lq = 1'b1;
    m_tq = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic bit model_zero();
    return (m[0] == 0) && (m[1] == 0) && (m[2] == 0) && (m[3] == 0);
  endfunction

  function automatic void model_apply(int d, bit ld, bit tk, bit e, bit c);
    bit kf, tr, ok;
    kf = m_lq && !ld;
    tr = !m_tq && tk;
    m_done = 1'b0;
    if (c) begin
      for (int i = 0; i < 4; i++) m[i] = 0;
    end else if (e && tr && !model_zero()) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i] > 0) begin
          m[i] = m[i] - 1;
          break;
        end
        m[i] = wrap[i];
      end
      m_done = model_zero();
    end else if (!e && kf && d <= 9) begin
      ok = (m[2] <= MIN_TENS_MAX);
`ifdef TIMER_ENTRY_LOCK_EN
      ok = ok && (m[3] == 0);
`endif
      if (ok) begin
        m[3] = m[2];
        m[2] = m[1];
        m[1] = m[0];
        m[0] = d;
      end
    end
    m_lq = ld;
    m_tq = tk;
  endfunction

  function automatic logic [17:0] dut_word();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.zero, bus.done};
  endfunction

  function automatic logic [17:0] model_word();
    return {4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0]), model_zero(), m_done};
  endfunction

  task automatic check18(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got mm:ss=%h zero=%b done=%b, want mm:ss=%h zero=%b done=%b",
               name, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge
  task automatic step(input logic [3:0] d, input bit ld, input bit tk, input bit e, input bit c);
    bus.D = d;
    bus.load = ld;
    bus.pgt_1Hz = tk;
    bus.en = e;
    bus.clear = c;
    model_apply(int'(d), ld, tk, e, c);
    @(posedge clk);
    #1;
    check18("model", dut_word(), model_word());
  endtask

  task automatic press(input logic [3:0] d);
    step(d, 1'b0, 1'b0, 1'b0, 1'b0);
    step(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  d;
    bit          ld;
    bit          tk;
    bit          e;
    bit          c;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[13];

  logic [3:0] rd;
  bit rld, rtk, ren, rclr;

  initial begin
    wrap[0] = 9;
    wrap[1] = SEC_TENS_WRAP;
    wrap[2] = 9;
    wrap[3] = 9;

    // Entry of 1,3,0 with held keys, bad digit, key in count mode, then clear
    tbl[0]  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0001, 1'b0, 1'b0}};
    tbl[1]  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0001, 1'b0, 1'b0}};
    tbl[2]  = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, {16'h0001, 1'b0, 1'b0}};
    tbl[3]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0013, 1'b0, 1'b0}};
    tbl[4]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0013, 1'b0, 1'b0}};
    tbl[5]  = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, {16'h0013, 1'b0, 1'b0}};
    tbl[6]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[7]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[8]  = '{4'd12, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[9]  = '{4'd12, 1'b1, 1'b0, 1'b0, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[10] = '{4'd5,  1'b0, 1'b0, 1'b1, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[11] = '{4'd5,  1'b1, 1'b0, 1'b0, 1'b0, {16'h0130, 1'b0, 1'b0}};
    tbl[12] = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0}};

    rst_n = 1'b0;
    bus.D = 4'd0;
    bus.load = 1'b1;
    bus.pgt_1Hz = 1'b0;
    bus.en = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check18("reset", dut_word(), {16'h0000, 1'b1, 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].d, tbl[i].ld, tbl[i].tk, tbl[i].e, tbl[i].c);
      check18($sformatf("table[%0d]", i), dut_word(), tbl[i].exp);
    end

    // Held key: one shift only
    for (int i = 0; i < 50; i++) step(4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check18("held_key", dut_word(), {16'h0007, 1'b0, 1'b0});

    // Borrow across minutes: 1:00 -> 0:59 -> 0:58
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    press(4'd1); press(4'd0); press(4'd0);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("borrow_059", dut_word(), {16'h0059, 1'b0, 1'b0});
    step(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("borrow_058", dut_word(), {16'h0058, 1'b0, 1'b0});

    // Terminal count: 0:02 -> 0:01 -> 0:00 (done one cycle) -> hold
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    press(4'd2);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("term_001", dut_word(), {16'h0001, 1'b0, 1'b0});
    step(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("term_done", dut_word(), {16'h0000, 1'b1, 1'b1});
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("term_done_drop", dut_word(), {16'h0000, 1'b1, 1'b0});
    step(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("term_hold", dut_word(), {16'h0000, 1'b1, 1'b0});

    // Clear beats a simultaneous tick; keys ignored in count mode
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd5);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    check18("clear_vs_tick", dut_word(), {16'h0000, 1'b1, 1'b0});
    step(4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    check18("key_in_count", dut_word(), {16'h0000, 1'b1, 1'b0});

    // Unnormalized sec_tens=7 counts down naturally: 0:70 -> 0:69
    press(4'd7); press(4'd0);
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check18("unnormalized", dut_word(), {16'h0069, 1'b0, 1'b0});

    // Overflow entry 9,9,9,9,5
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd5);
`ifdef TIMER_ENTRY_LOCK_EN
    check18("overflow", dut_word(), {16'h9999, 1'b0, 1'b0});
`else
    check18("overflow", dut_word(), {16'h9995, 1'b0, 1'b0});
`endif

    // Async reset mid-countdown
    step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    bus.pgt_1Hz = 1'b0;
    model_reset();
    #1;
    check18("reset_mid", dut_word(), {16'h0000, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check18("reset_hold", dut_word(), {16'h0000, 1'b1, 1'b0});
    rst_n = 1'b1;

    // Randomized traffic against the model
    rld = 1'b1; rtk = 1'b0; ren = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rld = ~rld;
      if ($urandom_range(0, 2) == 0) rtk = ~rtk;
      if ($urandom_range(0, 39) == 0) ren = ~ren;
      rclr = ($urandom_range(0, 149) == 0);
      rd = 4'($urandom_range(0, 11));
      step(rd, rld, rtk, ren, rclr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
